// File: rtl/mem_resp_pkg.sv
// Shared types and address checking for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_is_err(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] index;
        index = addr / WORD_BYTES;
        return ((addr % WORD_BYTES) != 0) || (index >= depth);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage with asynchronous read and byte-enabled synchronous write.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IDX_W       = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request, fixed-latency response.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_resp_state_t  state;
    logic [3:0]       cnt;
    logic             accept;
    logic             err;
    logic             mem_we;
    logic [IDX_W-1:0] index;
    logic [31:0]      mem_rdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign err       = addr_is_err(req_addr, DEPTH_WORDS);
    assign index     = req_addr[IDX_W+1:2];
    assign mem_we    = accept & req_we & ~err;

    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (req_be),
        .index (index),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_err   <= err;
                        rsp_rdata <= (req_we || err) ? '0 : mem_rdata;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Valid rises one edge after entering RESP, giving exactly LATENCY edges from acceptance.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
